// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: monitor state codes and latch output decode
package sr_latch_pkg;
  localparam logic [1:0] ST_RESET   = 2'b00;
  localparam logic [1:0] ST_SET     = 2'b01;
  localparam logic [1:0] ST_PENDING = 2'b10;
  localparam logic [1:0] ST_INVALID = 2'b11;
  function automatic logic [1:0] decode(input logic o, input logic n);
    return (o ^ n) ? (o ? ST_SET : ST_RESET) : ST_INVALID;
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-stage flop chain with selectable reset value
module bit_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= {STAGES{RESET_VALUE}};
    else chain <= {chain[STAGES-2:0], d};
  end
  assign q = chain[STAGES-1];
endmodule

// File: rtl/sr_latch_event_monitor.sv
// sr_latch_event_monitor: synchronizes SR latch outputs, filters invalid
// intervals and counts set/reset/invalid events with saturation
module sr_latch_event_monitor
  import sr_latch_pkg::*;
#(
  parameter int COUNT_WIDTH    = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int INVALID_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   latchOut,
  input  logic                   latchNotOut,
  input  logic                   clear,
  output logic [1:0]             state,
  output logic                   setPulse,
  output logic                   resetPulse,
  output logic                   invalidFlag,
  output logic [COUNT_WIDTH-1:0] setCount,
  output logic [COUNT_WIDTH-1:0] resetCount,
  output logic [COUNT_WIDTH-1:0] invalidCount
);
  localparam int PW = $clog2(INVALID_CYCLES + 1);
  localparam logic [PW-1:0] INV_LIM = PW'(INVALID_CYCLES);
  logic out_s, notout_s, last_valid, last_next, set_ev, reset_ev, inv_ev;
  logic [1:0] dec, state_next;
  logic [PW-1:0] pend_count, pend_next, pend_inc;
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_out (
    .clock(clock), .reset(reset), .d(latchOut), .q(out_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_notout (
    .clock(clock), .reset(reset), .d(latchNotOut), .q(notout_s)
  );
  function automatic logic [COUNT_WIDTH-1:0] bump(
    input logic [COUNT_WIDTH-1:0] cnt, input logic inc, input logic clr
  );
    return clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
  endfunction
  // in SET/RESET last_valid mirrors state, so one comparison covers every state
  always_comb begin
    dec        = decode(out_s, notout_s);
    pend_inc   = pend_count + PW'(1);
    state_next = state;
    last_next  = last_valid;
    pend_next  = pend_count;
    set_ev     = 1'b0;
    reset_ev   = 1'b0;
    inv_ev     = 1'b0;
    if (dec != ST_INVALID) begin
      state_next = dec;
      last_next  = dec == ST_SET;
      pend_next  = '0;
      set_ev     = dec == ST_SET && !last_valid;
      reset_ev   = dec == ST_RESET && last_valid;
    end else if (state == ST_RESET || state == ST_SET) begin
      pend_next  = PW'(1);
      inv_ev     = INVALID_CYCLES == 1;
      state_next = inv_ev ? ST_INVALID : ST_PENDING;
    end else if (state == ST_PENDING) begin
      pend_next  = pend_inc;
      inv_ev     = pend_inc == INV_LIM;
      state_next = inv_ev ? ST_INVALID : ST_PENDING;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_RESET;
      last_valid   <= 1'b0;
      pend_count   <= '0;
      setPulse     <= 1'b0;
      resetPulse   <= 1'b0;
      setCount     <= '0;
      resetCount   <= '0;
      invalidCount <= '0;
    end else begin
      state        <= state_next;
      last_valid   <= last_next;
      pend_count   <= pend_next;
      setPulse     <= set_ev;
      resetPulse   <= reset_ev;
      setCount     <= bump(setCount, set_ev, clear);
      resetCount   <= bump(resetCount, reset_ev, clear);
      invalidCount <= bump(invalidCount, inv_ev, clear);
    end
  end
  assign invalidFlag = state == ST_INVALID;
endmodule
